// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states and the
// load size/sign encodings carried in funct3.
package riscv_wb_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      WAIT_LD,
      READY
   } wb_state_e;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/riscv_load_align.sv
// Selects the addressed byte/halfword from a raw aligned memory word and
// sign/zero-extends it; flags unknown sizes and misaligned accesses.
module riscv_load_align
   import riscv_wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            addr_lo,
   input  logic [DATA_WIDTH-1:0] raw_data,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  fmt_err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw_data[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];
      data     = '0;
      fmt_err  = 1'b0;
      // Misaligned halfword/word accesses still return data, ignoring the low bits
      case (funct3)
         FUNCT3_LB:  data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         FUNCT3_LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         FUNCT3_LH: begin
            data    = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            fmt_err = addr_lo[0];
         end
         FUNCT3_LHU: begin
            data    = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            fmt_err = addr_lo[0];
         end
         FUNCT3_LW: begin
            data    = raw_data;
            fmt_err = (addr_lo != 2'b00);
         end
         default: begin
            data    = '0;
            fmt_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/riscv_wb_writer.sv
// Writeback stage: accepts retiring instructions, waits for load responses,
// and drives one register-file write per instruction plus hazard info.
module riscv_wb_writer
   import riscv_wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_wen,
   input  logic                  in_is_load,
   input  logic [2:0]            in_funct3,
   input  logic [1:0]            in_addr_lo,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic                  ld_rsp_valid,
   input  logic [DATA_WIDTH-1:0] ld_rsp_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  pend_ld_valid,
   output logic [ADDR_WIDTH-1:0] pend_ld_rd,
   output logic [CNT_WIDTH-1:0]  retire_cnt,
   output logic                  err
);

   wb_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                  wen_q, wen_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  ld_fmt_err;

   riscv_load_align #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_align (
      .funct3  (funct3_q),
      .addr_lo (addr_lo_q),
      .raw_data(ld_rsp_data),
      .data    (ld_data),
      .fmt_err (ld_fmt_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // The is_load flag is not kept separately: it is implied by entering WAIT_LD
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (accept) state_d = in_is_load ? WAIT_LD : READY;
         end
         WAIT_LD: begin
            if (ld_rsp_valid) state_d = READY;
         end
         READY: begin
            if (accept) state_d = in_is_load ? WAIT_LD : READY;
            else        state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      rd_d      = rd_q;
      wen_d     = wen_q;
      funct3_d  = funct3_q;
      addr_lo_d = addr_lo_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      if (accept) begin
         rd_d      = in_rd;
         wen_d     = in_wen;
         funct3_d  = in_funct3;
         addr_lo_d = in_addr_lo;
         result_d  = in_result;
      end else if (state_q == WAIT_LD && ld_rsp_valid) begin
         result_d = ld_data;
      end
      if (state_q == READY) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (ld_rsp_valid && state_q != WAIT_LD) err_d = 1'b1;
      if (ld_rsp_valid && state_q == WAIT_LD && ld_fmt_err) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q      <= '0;
         wen_q     <= 1'b0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         rd_q      <= rd_d;
         wen_q     <= wen_d;
         funct3_q  <= funct3_d;
         addr_lo_q <= addr_lo_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      in_ready      = (state_q == EMPTY) || (state_q == READY);
      accept        = in_valid && in_ready;
      wr_en         = (state_q == READY) && wen_q && (rd_q != '0);
      wr_addr       = rd_q;
      wr_data       = result_q;
      pend_ld_valid = (state_q == WAIT_LD) && wen_q && (rd_q != '0);
      pend_ld_rd    = rd_q;
      retire_cnt    = cnt_q;
      err           = err_q;
   end

endmodule
